// File: rtl/block_dispatch_pkg.sv
// Shared widths, FSM state encoding and bus payload types for the MP kernel-launch dispatcher.
package block_dispatch_pkg;

   localparam int unsigned NUM_BLOCKS    = 4;
   localparam int unsigned BLOCKID_DEPTH = $clog2(NUM_BLOCKS);
   localparam int unsigned NUM_WARPS     = 16;
   localparam int unsigned WARPID_DEPTH  = $clog2(NUM_WARPS);
   localparam int unsigned BLOCK_DIM     = 32;
   localparam int unsigned GRID_DIM      = 32;
   localparam int unsigned R_DATA_WIDTH  = 32;
   localparam int unsigned NUM_PARAMS    = 8;
   localparam int unsigned PARAM_DEPTH   = $clog2(NUM_PARAMS);
   localparam int unsigned NPARAM_W      = PARAM_DEPTH + 1;
   localparam int unsigned FREE_W        = WARPID_DEPTH + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WAIT  = 3'd2,
      INIT  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } dispatch_state_t;

   // Kernel descriptor captured on the launch handshake
   typedef struct packed {
      logic [GRID_DIM-1:0]     gdim;
      logic [BLOCK_DIM-1:0]    bdim;
      logic [GRID_DIM-1:0]     nblk;
      logic [WARPID_DEPTH-1:0] nwarp;
      logic [NPARAM_W-1:0]     nparam;
   } launch_desc_t;

   // Per-slot init bus toward the block trackers
   typedef struct packed {
      logic [NUM_BLOCKS-1:0]    bi;
      logic [BLOCKID_DEPTH-1:0] bid;
      logic [WARPID_DEPTH-1:0]  num_warp;
      logic [BLOCK_DIM-1:0]     bdim;
      logic [GRID_DIM-1:0]      gdim;
      logic [GRID_DIM-1:0]      bidx;
      logic [PARAM_DEPTH-1:0]   pwa;
      logic [R_DATA_WIDTH-1:0]  param;
      logic                     pwe;
   } init_bus_t;

endpackage

// File: rtl/block_dispatch_if.sv
// Launch, parameter, retire and block-init signals between the launch source and block_dispatch.
interface block_dispatch_if;
   import block_dispatch_pkg::*;

   logic                     launch_valid;
   logic                     launch_ready;
   logic [GRID_DIM-1:0]      l_gdim;
   logic [BLOCK_DIM-1:0]     l_bdim;
   logic [GRID_DIM-1:0]      l_nblk;
   logic [WARPID_DEPTH-1:0]  l_nwarp;
   logic [NPARAM_W-1:0]      l_nparam;
   logic                     p_valid;
   logic                     p_ready;
   logic [R_DATA_WIDTH-1:0]  p_data;
   logic                     blk_done;
   logic [BLOCKID_DEPTH-1:0] blk_done_bid;
   logic [NUM_BLOCKS-1:0]    bi_o;
   logic [BLOCKID_DEPTH-1:0] bid_init_o;
   logic [WARPID_DEPTH-1:0]  num_warp_o;
   logic [BLOCK_DIM-1:0]     bdim_o;
   logic [GRID_DIM-1:0]      gdim_o;
   logic [GRID_DIM-1:0]      bidx_o;
   logic [PARAM_DEPTH-1:0]   pwa_o;
   logic [R_DATA_WIDTH-1:0]  param_o;
   logic                     pwe_o;
   logic                     busy_o;
   logic                     kdone_o;

   modport slave (
      input  launch_valid, l_gdim, l_bdim, l_nblk, l_nwarp, l_nparam,
      input  p_valid, p_data, blk_done, blk_done_bid,
      output launch_ready, p_ready,
      output bi_o, bid_init_o, num_warp_o, bdim_o, gdim_o, bidx_o,
      output pwa_o, param_o, pwe_o, busy_o, kdone_o
   );

   modport master (
      output launch_valid, l_gdim, l_bdim, l_nblk, l_nwarp, l_nparam,
      output p_valid, p_data, blk_done, blk_done_bid,
      input  launch_ready, p_ready,
      input  bi_o, bid_init_o, num_warp_o, bdim_o, gdim_o, bidx_o,
      input  pwa_o, param_o, pwe_o, busy_o, kdone_o
   );

endinterface

// File: rtl/block_dispatch_slot_alloc.sv
// Block-slot occupancy and free-warp budget: lowest-free-slot pick, allocation on dispatch,
// release on block retire.
module block_dispatch_slot_alloc
   import block_dispatch_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_i,
   input  logic [BLOCKID_DEPTH-1:0] alloc_slot_i,
   input  logic                     retire_i,
   input  logic [BLOCKID_DEPTH-1:0] retire_slot_i,
   input  logic                     init_active_i,
   input  logic [BLOCKID_DEPTH-1:0] init_slot_i,
   input  logic [WARPID_DEPTH-1:0]  nwarp_i,
   output logic                     any_free_c,
   output logic [BLOCKID_DEPTH-1:0] free_slot_c,
   output logic [NUM_BLOCKS-1:0]    slot_busy_o,
   output logic [FREE_W-1:0]        free_warps_o
);

   localparam int unsigned SUM_W = FREE_W + 1;

   logic [NUM_BLOCKS-1:0] slot_busy_q, slot_busy_d;
   logic [FREE_W-1:0]     free_warps_q, free_warps_d;
   logic                  retire_ok;
   logic [SUM_W-1:0]      warp_sum;

   // Lowest-index free slot
   always_comb begin
      any_free_c  = ~&slot_busy_q;
      free_slot_c = '0;
      for (int i = int'(NUM_BLOCKS) - 1; i >= 0; i--) begin
         if (!slot_busy_q[i]) free_slot_c = BLOCKID_DEPTH'(i);
      end
   end

   // A retire only counts for an occupied slot that is not mid-init
   always_comb begin
      retire_ok   = retire_i && slot_busy_q[retire_slot_i] &&
                    !(init_active_i && (retire_slot_i == init_slot_i));
      slot_busy_d = slot_busy_q;
      if (retire_ok) slot_busy_d[retire_slot_i] = 1'b0;
      if (alloc_i)   slot_busy_d[alloc_slot_i]  = 1'b1;

      warp_sum = SUM_W'(free_warps_q)
               + (retire_ok ? SUM_W'(nwarp_i) : SUM_W'(0))
               - (alloc_i   ? SUM_W'(nwarp_i) : SUM_W'(0));
      free_warps_d = (warp_sum > SUM_W'(NUM_WARPS)) ? FREE_W'(NUM_WARPS) : FREE_W'(warp_sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_busy_q  <= '0;
         free_warps_q <= FREE_W'(NUM_WARPS);
      end else begin
         slot_busy_q  <= slot_busy_d;
         free_warps_q <= free_warps_d;
      end
   end

   assign slot_busy_o  = slot_busy_q;
   assign free_warps_o = free_warps_q;

endmodule

// File: rtl/block_dispatch.sv
// Kernel-launch front end for one MP: takes a launch descriptor and parameter words, then walks
// the grid into free block slots. Optional BLOCK_DISPATCH_PERF_EN adds dispatch/stall counters.
module block_dispatch
   import block_dispatch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   block_dispatch_if.slave bus
`ifdef BLOCK_DISPATCH_PERF_EN
   ,
   output logic [31:0]     perf_blk_o,
   output logic [31:0]     perf_stall_o
`endif
);

   dispatch_state_t          state_q, state_d;
   launch_desc_t             desc_q, desc_d;
   init_bus_t                init_q, init_d;
   logic [GRID_DIM-1:0]      bidx_q, bidx_d;
   logic [PARAM_DEPTH-1:0]   k_q, k_d, last_k;
   logic [BLOCKID_DEPTH-1:0] slot_q, slot_d;
   logic                     launch_ready_q, launch_ready_d;
   logic                     p_ready_q, p_ready_d;
   logic                     busy_q, busy_d;
   logic                     kdone_q, kdone_d;
   logic                     launch_xfer, load_xfer, dispatch_ok, alloc, buf_we, init_active;
   logic [NPARAM_W-1:0]      nparam_in;
   logic [R_DATA_WIDTH-1:0]  param_buf [NUM_PARAMS];
   logic                     any_free_c;
   logic [BLOCKID_DEPTH-1:0] free_slot_c;
   logic [NUM_BLOCKS-1:0]    slot_busy;
   logic [FREE_W-1:0]        free_warps;

   assign init_active = (state_q == INIT);

   block_dispatch_slot_alloc u_slot_alloc (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc_i      (alloc),
      .alloc_slot_i (slot_q),
      .retire_i     (bus.blk_done),
      .retire_slot_i(bus.blk_done_bid),
      .init_active_i(init_active),
      .init_slot_i  (slot_q),
      .nwarp_i      (desc_q.nwarp),
      .any_free_c   (any_free_c),
      .free_slot_c  (free_slot_c),
      .slot_busy_o  (slot_busy),
      .free_warps_o (free_warps)
   );

   // Next state plus next values of every registered output
   always_comb begin
      state_d     = state_q;
      desc_d      = desc_q;
      bidx_d      = bidx_q;
      k_d         = k_q;
      slot_d      = slot_q;
      alloc       = 1'b0;
      buf_we      = 1'b0;
      launch_xfer = launch_ready_q && bus.launch_valid;
      load_xfer   = p_ready_q && bus.p_valid;
      dispatch_ok = any_free_c && (free_warps >= FREE_W'(desc_q.nwarp));
      last_k      = (desc_q.nparam == '0) ? '0 : PARAM_DEPTH'(desc_q.nparam - NPARAM_W'(1));
      nparam_in   = (bus.l_nparam > NPARAM_W'(NUM_PARAMS)) ? NPARAM_W'(NUM_PARAMS) : bus.l_nparam;

      case (state_q)
         IDLE: begin
            if (launch_xfer) begin
               desc_d.gdim   = bus.l_gdim;
               desc_d.bdim   = bus.l_bdim;
               desc_d.nblk   = bus.l_nblk;
               desc_d.nwarp  = (bus.l_nwarp == '0) ? WARPID_DEPTH'(1) : bus.l_nwarp;
               desc_d.nparam = nparam_in;
               bidx_d        = '0;
               k_d           = '0;
               if (nparam_in != '0)      state_d = LOAD;
               else if (bus.l_nblk != '0) state_d = WAIT;
               else                       state_d = DONE;
            end
         end
         LOAD: begin
            if (load_xfer) begin
               buf_we = 1'b1;
               if (k_q == last_k) begin
                  k_d     = '0;
                  state_d = (desc_q.nblk != '0) ? WAIT : DONE;
               end else begin
                  k_d = k_q + PARAM_DEPTH'(1);
               end
            end
         end
         WAIT: begin
            if (dispatch_ok) begin
               slot_d  = free_slot_c;
               k_d     = '0;
               state_d = INIT;
            end
         end
         INIT: begin
            alloc = (k_q == '0);
            if (k_q == last_k) begin
               k_d     = '0;
               bidx_d  = bidx_q + GRID_DIM'(1);
               state_d = (bidx_d < desc_q.nblk) ? WAIT : DRAIN;
            end else begin
               k_d = k_q + PARAM_DEPTH'(1);
            end
         end
         DRAIN:   if (slot_busy == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      launch_ready_d = (state_d == IDLE);
      p_ready_d      = (state_d == LOAD);
      busy_d         = (state_d != IDLE);
      kdone_d        = (state_d == DONE);
      init_d         = '0;
      if (state_d == INIT) begin
         init_d.bi       = NUM_BLOCKS'(1) << slot_d;
         init_d.bid      = slot_d;
         init_d.num_warp = desc_d.nwarp;
         init_d.bdim     = desc_d.bdim;
         init_d.gdim     = desc_d.gdim;
         init_d.bidx     = bidx_d;
         if (desc_d.nparam != '0) begin
            init_d.pwe   = 1'b1;
            init_d.pwa   = k_d;
            init_d.param = param_buf[k_d];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         desc_q         <= '0;
         init_q         <= '0;
         bidx_q         <= '0;
         k_q            <= '0;
         slot_q         <= '0;
         launch_ready_q <= 1'b1;
         p_ready_q      <= 1'b0;
         busy_q         <= 1'b0;
         kdone_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         desc_q         <= desc_d;
         init_q         <= init_d;
         bidx_q         <= bidx_d;
         k_q            <= k_d;
         slot_q         <= slot_d;
         launch_ready_q <= launch_ready_d;
         p_ready_q      <= p_ready_d;
         busy_q         <= busy_d;
         kdone_q        <= kdone_d;
      end
   end

   // Parameter buffer holds data only; contents are meaningless until loaded
   always_ff @(posedge clk) begin
      if (buf_we) param_buf[k_q] <= bus.p_data;
   end

`ifdef BLOCK_DISPATCH_PERF_EN
   logic [31:0] perf_blk_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_blk_q   <= '0;
         perf_stall_q <= '0;
      end else if (launch_xfer) begin
         perf_blk_q   <= '0;
         perf_stall_q <= '0;
      end else if (state_q == WAIT) begin
         if (dispatch_ok && (perf_blk_q != '1))    perf_blk_q   <= perf_blk_q + 32'd1;
         if (!dispatch_ok && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_blk_o   = perf_blk_q;
   assign perf_stall_o = perf_stall_q;
`endif

   assign bus.launch_ready = launch_ready_q;
   assign bus.p_ready      = p_ready_q;
   assign bus.busy_o       = busy_q;
   assign bus.kdone_o      = kdone_q;
   assign bus.bi_o         = init_q.bi;
   assign bus.bid_init_o   = init_q.bid;
   assign bus.num_warp_o   = init_q.num_warp;
   assign bus.bdim_o       = init_q.bdim;
   assign bus.gdim_o       = init_q.gdim;
   assign bus.bidx_o       = init_q.bidx;
   assign bus.pwa_o        = init_q.pwa;
   assign bus.param_o      = init_q.param;
   assign bus.pwe_o        = init_q.pwe;

endmodule

// File: tb/tb_block_dispatch.sv
// Directed self-checking bench for block_dispatch; inputs driven and outputs sampled on negedge.
module tb_block_dispatch;
   import block_dispatch_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] prm [4];

   always #5 clk = ~clk;

   block_dispatch_if bus();

`ifdef BLOCK_DISPATCH_PERF_EN
   logic [31:0] perf_blk, perf_stall;
   bit mon_on = 1'b0;
   bit mon_prev_bi = 1'b0;
   int mon_disp = 0;
   int mon_wait = 0;

   // Counts visible WAIT cycles of the six-block grid: busy, no burst, not LOAD/DONE, grid not exhausted
   always @(negedge clk) begin
      if (mon_on) begin
         if ((bus.bi_o != '0) && !mon_prev_bi) mon_disp++;
         else if (bus.busy_o && (bus.bi_o == '0) && !bus.p_ready && !bus.kdone_o && (mon_disp < 6))
            mon_wait++;
         mon_prev_bi = (bus.bi_o != '0);
      end
   end
`endif

   block_dispatch dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
`ifdef BLOCK_DISPATCH_PERF_EN
      ,
      .perf_blk_o  (perf_blk),
      .perf_stall_o(perf_stall)
`endif
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      bus.launch_valid = 1'b0;
      bus.l_gdim       = '0;
      bus.l_bdim       = '0;
      bus.l_nblk       = '0;
      bus.l_nwarp      = '0;
      bus.l_nparam     = '0;
      bus.p_valid      = 1'b0;
      bus.p_data       = '0;
      bus.blk_done     = 1'b0;
      bus.blk_done_bid = '0;
   endtask

   task automatic launch(input logic [31:0] gd, input logic [31:0] bd, input logic [31:0] nb,
                         input logic [3:0] nw, input logic [3:0] np);
      int w = 0;
      while (!bus.launch_ready && w < 100) begin step(); w++; end
      check("launch_ready", bus.launch_ready, 1);
      bus.launch_valid = 1'b1;
      bus.l_gdim       = gd;
      bus.l_bdim       = bd;
      bus.l_nblk       = nb;
      bus.l_nwarp      = nw;
      bus.l_nparam     = np;
      step();
      bus.launch_valid = 1'b0;
   endtask

   task automatic send_params(input int n);
      check("p_ready", bus.p_ready, 1);
      for (int i = 0; i < n; i++) begin
         bus.p_valid = 1'b1;
         bus.p_data  = prm[i];
         step();
      end
      bus.p_valid = 1'b0;
   endtask

   task automatic wait_bi(input string tag);
      int w = 0;
      while ((bus.bi_o == '0) && w < 100) begin step(); w++; end
      check({tag, "_seen"}, bus.bi_o != '0, 1);
   endtask

   task automatic retire(input logic [1:0] slot);
      bus.blk_done     = 1'b1;
      bus.blk_done_bid = slot;
      step();
      bus.blk_done     = 1'b0;
   endtask

   task automatic idle_bursts(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (bus.bi_o != '0) seen++;
      end
      check(tag, seen, 0);
   endtask

   task automatic wait_kdone(input string tag);
      int w = 0;
      while (!bus.kdone_o && w < 200) begin step(); w++; end
      check({tag, "_kdone"}, bus.kdone_o, 1);
      step();
      check({tag, "_kdone_pulse"}, bus.kdone_o, 0);
      check({tag, "_launch_ready"}, bus.launch_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      drive_idle();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("rst_launch_ready", bus.launch_ready, 1);
      check("rst_p_ready", bus.p_ready, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_bi", bus.bi_o, 0);
      check("rst_pwe", bus.pwe_o, 0);
      check("rst_kdone", bus.kdone_o, 0);

      // 1: single block, three params
      prm[0] = 32'hAAAA_0001; prm[1] = 32'hBBBB_0002; prm[2] = 32'hCCCC_0003;
      launch(32'd7, 32'd64, 32'd1, 4'd4, 4'd3);
      send_params(3);
      wait_bi("t1");
      for (int i = 0; i < 3; i++) begin
         check("t1_bi", bus.bi_o, 4'b0001);
         check("t1_bid", bus.bid_init_o, 0);
         check("t1_pwe", bus.pwe_o, 1);
         check("t1_pwa", bus.pwa_o, i);
         check("t1_param", bus.param_o, prm[i]);
         check("t1_bidx", bus.bidx_o, 0);
         check("t1_nwarp", bus.num_warp_o, 4);
         check("t1_bdim", bus.bdim_o, 64);
         check("t1_gdim", bus.gdim_o, 7);
         step();
      end
      check("t1_burst_end", bus.bi_o, 0);
      check("t1_drain_busy", bus.busy_o, 1);
      retire(2'd0);
      wait_kdone("t1");

      // 2: six blocks over four slots, retire-driven refill
      prm[0] = 32'h1234_5678;
`ifdef BLOCK_DISPATCH_PERF_EN
      mon_on = 1'b1;
`endif
      launch(32'd6, 32'd32, 32'd6, 4'd4, 4'd1);
      send_params(1);
      for (int b = 0; b < 4; b++) begin
         wait_bi("t2");
         check("t2_bi", bus.bi_o, 4'b0001 << b);
         check("t2_bid", bus.bid_init_o, b);
         check("t2_bidx", bus.bidx_o, b);
         check("t2_param", bus.param_o, 32'h1234_5678);
         step();
         check("t2_burst_len", bus.bi_o, 0);
      end
      idle_bursts("t2_stall_no_dispatch", 8);
      retire(2'd2);
      wait_bi("t2_r2");
      check("t2_r2_bi", bus.bi_o, 4'b0100);
      check("t2_r2_bidx", bus.bidx_o, 4);
      step();
      retire(2'd1);
      wait_bi("t2_r1");
      check("t2_r1_bi", bus.bi_o, 4'b0010);
      check("t2_r1_bidx", bus.bidx_o, 5);
      step();
      retire(2'd0); retire(2'd1); retire(2'd2); retire(2'd3);
      wait_kdone("t2");
`ifdef BLOCK_DISPATCH_PERF_EN
      mon_on = 1'b0;
      check("t2_perf_blk", perf_blk, 6);
      check("t2_perf_stall", perf_stall, mon_wait - 6);
`endif

      // 3: warp budget limits to two slots; ignored retires; retire-to-dispatch latency
      prm[0] = 32'h0000_00A0; prm[1] = 32'h0000_00A1;
      launch(32'd3, 32'd16, 32'd3, 4'd8, 4'd2);
      send_params(2);
      wait_bi("t3_b0");
      check("t3_b0_bi", bus.bi_o, 4'b0001);
      check("t3_b0_nwarp", bus.num_warp_o, 8);
      step();
      check("t3_b0_pwa1", bus.pwa_o, 1);
      check("t3_b0_param1", bus.param_o, 32'h0000_00A1);
      step();
      check("t3_b0_end", bus.bi_o, 0);
      wait_bi("t3_b1");
      check("t3_b1_bi", bus.bi_o, 4'b0010);
      step();
      check("t3_b1_second", bus.bi_o, 4'b0010);
      retire(2'd1);
      check("t3_b1_end", bus.bi_o, 0);
      idle_bursts("t3_init_retire_ignored", 6);
      retire(2'd3);
      idle_bursts("t3_free_retire_ignored", 6);
      check("t3_busy", bus.busy_o, 1);
      bus.blk_done = 1'b1; bus.blk_done_bid = 2'd0;
      step();
      bus.blk_done = 1'b0;
      check("t3_no_bypass", bus.bi_o, 0);
      step();
      check("t3_dispatch_next", bus.bi_o, 4'b0001);
      check("t3_b2_bidx", bus.bidx_o, 2);
      step(); step();
      retire(2'd0); retire(2'd1);
      wait_kdone("t3");

      // 4: no params, nwarp 0 treated as 1; empty grid
      launch(32'd2, 32'd8, 32'd2, 4'd0, 4'd0);
      wait_bi("t4_b0");
      check("t4_b0_bi", bus.bi_o, 4'b0001);
      check("t4_b0_pwe", bus.pwe_o, 0);
      check("t4_b0_nwarp", bus.num_warp_o, 1);
      step();
      check("t4_b0_len", bus.bi_o, 0);
      wait_bi("t4_b1");
      check("t4_b1_bi", bus.bi_o, 4'b0010);
      check("t4_b1_bidx", bus.bidx_o, 1);
      check("t4_b1_pwe", bus.pwe_o, 0);
      step();
      check("t4_b1_len", bus.bi_o, 0);
      retire(2'd0); retire(2'd1);
      wait_kdone("t4");
      launch(32'd1, 32'd1, 32'd0, 4'd1, 4'd2);
      send_params(2);
      check("t4_nblk0_kdone", bus.kdone_o, 1);
      check("t4_nblk0_bi", bus.bi_o, 0);
      step();
      check("t4_nblk0_pulse", bus.kdone_o, 0);
      launch(32'd1, 32'd1, 32'd0, 4'd1, 4'd0);
      check("t4_empty_kdone", bus.kdone_o, 1);
      step();

      // 5: reset asserted mid-burst
      prm[0] = 32'h5; prm[1] = 32'h6; prm[2] = 32'h7;
      launch(32'd1, 32'd4, 32'd1, 4'd2, 4'd3);
      send_params(3);
      wait_bi("t5");
      step();
      check("t5_mid_init", bus.pwe_o, 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_bi", bus.bi_o, 0);
      check("t5_rst_pwe", bus.pwe_o, 0);
      check("t5_rst_param", bus.param_o, 0);
      check("t5_rst_busy", bus.busy_o, 0);
      check("t5_rst_launch_ready", bus.launch_ready, 1);
      step();
      rst_n = 1'b1;
      idle_bursts("t5_after_rst_quiet", 4);
      check("t5_after_rst_kdone", bus.kdone_o, 0);
      check("t5_after_rst_busy", bus.busy_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
